// File: rtl/fetch_buffer_pkg.sv
// Shared fetch/decode definitions: instruction field layout and queue sizing helper.
package fetch_buffer_pkg;

  localparam int INSTR_W  = 8;
  localparam int FUNC_MSB = 7;
  localparam int FUNC_LSB = 6;
  localparam int RDST_MSB = 5;
  localparam int RDST_LSB = 3;
  localparam int RSRC_MSB = 2;
  localparam int RSRC_LSB = 0;

  // Occupancy needs one extra bit so a full queue (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO holding {pc, instr} pairs; clear empties it in one cycle.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  input  logic                      clear,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [W-1:0]              head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: sequential PC issue to a 1-cycle imem, credit-limited so responses always fit
// in the prefetch queue; flush redirects the PC and drops queued and in-flight work.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [PC_W-1:0]           imem_addr,
  input  logic [INSTR_W-1:0]        imem_rdata,
  output logic [INSTR_W-1:0]        instr,
  output logic [PC_W-1:0]           pc_out,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  input  logic                      flush,
  input  logic [PC_W-1:0]           flush_pc,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic [PC_W-1:0]         fetch_pc;
  logic [PC_W-1:0]         issued_pc;
  logic                    inflight;
  logic [CW:0]             used;
  logic                    push;
  logic                    pop;
  logic [PC_W+INSTR_W-1:0] head;
  logic [INSTR_W-1:0]      head_instr;

  // An outstanding read already owns a queue slot, so it counts against the credit.
  assign used        = (CW+1)'(count) + (CW+1)'(inflight);
  assign imem_req    = !reset && !flush && (used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign push        = inflight && !flush;
  assign instr_valid = (count != '0) && !flush;
  assign pop         = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= '0;
      issued_pc <= '0;
      inflight  <= 1'b0;
    end else if (flush) begin
      fetch_pc  <= flush_pc;
      inflight  <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc  <= fetch_pc + PC_W'(1);
        issued_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .W     (PC_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({issued_pc, imem_rdata}),
    .pop       (pop),
    .clear     (flush),
    .count     (count),
    .head      (head)
  );

  assign head_instr = head[INSTR_W-1:0];
  assign pc_out     = head[PC_W+INSTR_W-1:INSTR_W];
  assign instr      = {head_instr[FUNC_MSB:FUNC_LSB],
                       head_instr[RDST_MSB:RDST_LSB],
                       head_instr[RSRC_MSB:RSRC_LSB]};

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer; imem model returns 8'hA0 + addr one cycle after each read.
module tb_fetch_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [4:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic [7:0] instr;
  logic [4:0] pc_out;
  logic       instr_valid;
  logic       instr_ready;
  logic       flush;
  logic [4:0] flush_pc;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= 8'hA0 + {3'b000, imem_addr};

  fetch_buffer #(.DEPTH(4), .PC_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .count       (count)
  );

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; flush_pc = 5'd0; instr_ready = 1'b0;
    #2;
    total++;
    if ({instr_valid, imem_req} !== 2'b00 || count !== 3'd0 || pc_out !== 5'd0 || instr !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: v=%b req=%b cnt=%0d pc=%0d instr=%h, want all zero",
               instr_valid, imem_req, count, pc_out, instr);
    end
  endtask

  task automatic test_free_run();
    logic [4:0] p;
    @(negedge clk); reset = 1'b0; instr_ready = 1'b1; #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin
      bad++; $display("FAIL fr_first_req: req=%b addr=%0d, want req=1 addr=0", imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL fr_latency: valid=%b one cycle after request, want 0", instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p = 5'(i);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== p || instr !== 8'hA0 + p || count !== 3'd1) begin
        bad++;
        $display("FAIL fr_seq[%0d]: v=%b pc=%0d instr=%h cnt=%0d, want v=1 pc=%0d instr=%h cnt=1",
                 i, instr_valid, pc_out, instr, count, p, 8'hA0 + p);
      end
    end
  endtask

  task automatic test_redirect();
    logic [4:0] p;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || pc_out !== 5'd3 || instr !== 8'hA3) begin
      bad++; $display("FAIL rd_pre: v=%b pc=%0d instr=%h, want v=1 pc=3 instr=a3", instr_valid, pc_out, instr);
    end
    flush = 1'b1; flush_pc = 5'd20; #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL rd_flush_cycle: v=%b req=%b, want 0 0", instr_valid, imem_req);
    end
    @(negedge clk); flush = 1'b0; #1;
    total++;
    if (count !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 5'd20) begin
      bad++;
      $display("FAIL rd_resume: cnt=%0d v=%b req=%b addr=%0d, want cnt=0 v=0 req=1 addr=20",
               count, instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL rd_gap: v=%b, want 0", instr_valid);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      p = 5'(20 + i);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== p || instr !== 8'hA0 + p) begin
        bad++;
        $display("FAIL rd_seq[%0d]: v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 i, instr_valid, pc_out, instr, p, 8'hA0 + p);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [4:0] p;
    @(negedge clk);
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== 5'd22 || instr !== 8'hB6) begin
        bad++;
        $display("FAIL bp_hold[%0d]: v=%b pc=%0d instr=%h, want v=1 pc=22 instr=b6",
                 i, instr_valid, pc_out, instr);
      end
    end
    total++;
    if (count !== 3'd4 || imem_req !== 1'b0) begin
      bad++; $display("FAIL bp_full: cnt=%0d req=%b, want cnt=4 req=0", count, imem_req);
    end
    instr_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      p = 5'(22 + i);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== p || instr !== 8'hA0 + p) begin
        bad++;
        $display("FAIL bp_drain[%0d]: v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 i, instr_valid, pc_out, instr, p, 8'hA0 + p);
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] wpc [4];
    logic [7:0] wins [4];
    wpc  = '{5'd30, 5'd31, 5'd0, 5'd1};
    wins = '{8'hBE, 8'hBF, 8'hA0, 8'hA1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== wpc[i] || instr !== wins[i]) begin
        bad++;
        $display("FAIL wrap[%0d]: v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 i, instr_valid, pc_out, instr, wpc[i], wins[i]);
      end
    end
  endtask

  task automatic test_flush_full();
    logic [4:0] p;
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (count !== 3'd4 || imem_req !== 1'b0 || pc_out !== 5'd2) begin
      bad++; $display("FAIL ff_full: cnt=%0d req=%b pc=%0d, want cnt=4 req=0 pc=2", count, imem_req, pc_out);
    end
    instr_ready = 1'b1; flush = 1'b1; flush_pc = 5'd12; #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL ff_flush_cycle: v=%b req=%b, want 0 0", instr_valid, imem_req);
    end
    @(negedge clk); flush = 1'b0; #1;
    total++;
    if (count !== 3'd0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL ff_cleared: cnt=%0d v=%b, want 0 0", count, instr_valid);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL ff_gap: v=%b, want 0", instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p = 5'(12 + i);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== p || instr !== 8'hA0 + p) begin
        bad++;
        $display("FAIL ff_seq[%0d]: v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 i, instr_valid, pc_out, instr, p, 8'hA0 + p);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (count !== 3'd3 || instr_valid !== 1'b1 || pc_out !== 5'd16) begin
      bad++; $display("FAIL ar_pre: cnt=%0d v=%b pc=%0d, want cnt=3 v=1 pc=16", count, instr_valid, pc_out);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({instr_valid, imem_req} !== 2'b00 || count !== 3'd0 || pc_out !== 5'd0 || instr !== 8'h00) begin
      bad++;
      $display("FAIL ar_immediate: v=%b req=%b cnt=%0d pc=%0d instr=%h, want all zero",
               instr_valid, imem_req, count, pc_out, instr);
    end
    #1 reset = 1'b0; instr_ready = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin
      bad++; $display("FAIL ar_restart: req=%b addr=%0d, want req=1 addr=0", imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL ar_gap: v=%b, want 0", instr_valid);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== 5'(i) || instr !== 8'hA0 + 8'(i)) begin
        bad++;
        $display("FAIL ar_seq[%0d]: v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 i, instr_valid, pc_out, instr, i, 8'hA0 + 8'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_redirect();
    test_back_pressure();
    test_wrap();
    test_flush_full();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
